// File: rtl/systolic_tile_engine_pkg.sv
// rtl/systolic_tile_engine_pkg.sv - shared widths, write-phase codes and controller states
package systolic_tile_engine_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int AXIS_W_DEF = 3;
    localparam int K_LEN_DEF  = 8;

    localparam logic [1:0] MSEL_IDLE = 2'd0;
    localparam logic [1:0] MSEL_C1   = 2'd1;
    localparam logic [1:0] MSEL_C23  = 2'd2;
    localparam logic [1:0] MSEL_C4   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_WR1  = 3'd2,
        ST_WR2  = 3'd3,
        ST_WR3  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_tile_engine_pe.sv
// rtl/systolic_tile_engine_pe.sv - one unsigned multiply-accumulate cell of the 2x2 array
module systolic_pe
    import systolic_tile_engine_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   acc
);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] w_prod;

    // Full-width product; the running sum simply wraps.
    assign w_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/systolic_tile_engine.sv
// rtl/systolic_tile_engine.sv - 8x8 matrix product as sixteen 2x2 tiles streamed to tile memory
module systolic_tile_engine
    import systolic_tile_engine_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AXIS_W = AXIS_W_DEF,
    parameter int K_LEN  = K_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     a0,
    input  logic [DATA_W-1:0]     a1,
    input  logic [DATA_W-1:0]     b0,
    input  logic [DATA_W-1:0]     b1,
    output logic [2*DATA_W-1:0]   c1,
    output logic [2*DATA_W-1:0]   c2,
    output logic [2*DATA_W-1:0]   c3,
    output logic [2*DATA_W-1:0]   c4,
    output logic [AXIS_W-1:0]     x,
    output logic [AXIS_W-1:0]     y,
    output logic [1:0]            mem_sel,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [KW-1:0]     K_LAST    = KW'(K_LEN - 1);
    localparam logic [AXIS_W-1:0] AXIS_LAST = AXIS_W'((1 << AXIS_W) - 2);
    localparam logic [AXIS_W-1:0] AXIS_STEP = AXIS_W'(2);

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [AXIS_W-1:0]   r_x;
    logic [AXIS_W-1:0]   r_y;
    logic [1:0]          r_mem_sel;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_beat;
    logic                w_last_tile;
    logic                w_clr;

    assign w_beat      = in_valid && r_in_ready;
    assign w_last_tile = (r_x == AXIS_LAST) && (r_y == AXIS_LAST);
    // The final tile keeps its accumulators so c1..c4 stay readable after done.
    assign w_clr       = ((r_state == ST_IDLE) && start) ||
                         ((r_state == ST_WR3) && !w_last_tile);

    systolic_pe #(.DATA_W(DATA_W)) u_pe11 (
        .clk(clk), .reset(reset), .clr(w_clr), .en(w_beat), .a(a0), .b(b0), .acc(c1)
    );
    systolic_pe #(.DATA_W(DATA_W)) u_pe12 (
        .clk(clk), .reset(reset), .clr(w_clr), .en(w_beat), .a(a0), .b(b1), .acc(c2)
    );
    systolic_pe #(.DATA_W(DATA_W)) u_pe21 (
        .clk(clk), .reset(reset), .clr(w_clr), .en(w_beat), .a(a1), .b(b0), .acc(c3)
    );
    systolic_pe #(.DATA_W(DATA_W)) u_pe22 (
        .clk(clk), .reset(reset), .clr(w_clr), .en(w_beat), .a(a1), .b(b1), .acc(c4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_mem_sel  <= MSEL_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_ACC;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_k        <= '0;
                    end
                end
                ST_ACC: begin
                    if (w_beat) begin
                        if (r_k == K_LAST) begin
                            r_state    <= ST_WR1;
                            r_in_ready <= 1'b0;
                            r_mem_sel  <= MSEL_C1;
                            r_k        <= '0;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                ST_WR1: begin
                    r_state   <= ST_WR2;
                    r_mem_sel <= MSEL_C23;
                end
                ST_WR2: begin
                    r_state   <= ST_WR3;
                    r_mem_sel <= MSEL_C4;
                end
                ST_WR3: begin
                    r_mem_sel <= MSEL_IDLE;
                    r_k       <= '0;
                    if (w_last_tile) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_ACC;
                        r_in_ready <= 1'b1;
                        if (r_y == AXIS_LAST) begin
                            r_y <= '0;
                            r_x <= r_x + AXIS_STEP;
                        end else begin
                            r_y <= r_y + AXIS_STEP;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_sel  <= MSEL_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign x        = r_x;
    assign y        = r_y;
    assign mem_sel  = r_mem_sel;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_systolic_tile_engine.sv
// tb/tb_systolic_tile_engine.sv - scoreboard bench for the systolic tile engine
module tb_systolic_tile_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [15:0] c1, c2, c3, c4;
    logic [2:0]  x, y;
    logic [1:0]  mem_sel;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mat_a [8][8];
    logic [7:0] mat_b [8][8];

    typedef struct {
        logic [2:0]  tx;
        logic [2:0]  ty;
        logic [15:0] e1, e2, e3, e4;
    } tile_t;

    tile_t exp_q[$];

    systolic_tile_engine dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .x(x), .y(y), .mem_sel(mem_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dot(input int i, input int j);
        logic [15:0] s = '0;
        for (int k = 0; k < 8; k++) s = s + 16'(mat_a[i][k]) * 16'(mat_b[k][j]);
        return s;
    endfunction

    task automatic set_mats(input int kind);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                case (kind)
                    0: begin mat_a[i][j] = 8'd1;   mat_b[i][j] = 8'd1;   end
                    1: begin mat_a[i][j] = 8'd255; mat_b[i][j] = 8'd255; end
                    default: begin mat_a[i][j] = 8'(i + 1); mat_b[i][j] = 8'(j + 1); end
                endcase
            end
        end
    endtask

    task automatic drive(input bit bubble, input int limit);
        int beat = 0, pushed = 0, budget = 0, t, kk, tx, ty;
        bit pend = 0, bub_done = 0;
        tile_t e;
        while (beat < limit && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (pend) begin
                beat++;
                bub_done = 0;
            end
            pend = 0;
            if (beat >= limit) break;
            t  = beat / 8;
            kk = beat % 8;
            tx = (t / 4) * 2;
            ty = (t % 4) * 2;
            if (kk == 0 && pushed == t) begin
                e.tx = 3'(tx); e.ty = 3'(ty);
                e.e1 = dot(tx, ty);     e.e2 = dot(tx, ty + 1);
                e.e3 = dot(tx + 1, ty); e.e4 = dot(tx + 1, ty + 1);
                exp_q.push_back(e);
                pushed++;
            end
            a0 = mat_a[tx][kk];
            a1 = mat_a[tx + 1][kk];
            b0 = mat_b[kk][ty];
            b1 = mat_b[kk][ty + 1];
            if (bubble && !bub_done) begin
                in_valid = 1'b0;
                if (in_ready) bub_done = 1;
            end else begin
                in_valid = 1'b1;
            end
            pend = in_valid && in_ready;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (beat < limit) begin
            n_bad++;
            $display("FAIL drive_budget beats=%0d required=%0d", beat, limit);
        end
    endtask

    task automatic monitor(input int n_tiles, input int exp_period, input int exp_first, input int exp_done);
        int tiles = 0, cyc = 0, last_wr1 = -1, w;
        tile_t e;
        while (tiles < n_tiles && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                n_cmp++; n_bad++;
                $display("FAIL early_done cyc=%0d tiles=%0d required=%0d", cyc, tiles, n_tiles);
            end
            if (mem_sel == 2'd1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_tile x=%0d y=%0d", x, y);
                    e = '{3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0};
                end else begin
                    e = exp_q.pop_front();
                end
                n_cmp++;
                if (last_wr1 < 0) begin
                    if (cyc !== exp_first) begin
                        n_bad++;
                        $display("FAIL first_wr1_cycle got=%0d required=%0d", cyc, exp_first);
                    end
                end else if (cyc - last_wr1 !== exp_period) begin
                    n_bad++;
                    $display("FAIL tile_period got=%0d required=%0d", cyc - last_wr1, exp_period);
                end
                last_wr1 = cyc;
                for (int ph = 1; ph <= 3; ph++) begin
                    if (ph > 1) begin
                        @(negedge clk);
                        cyc++;
                    end
                    n_cmp++;
                    if (mem_sel !== 2'(ph) || busy !== 1'b1 || in_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL wr_phase got sel=%0d busy=%0b rdy=%0b required sel=%0d busy=1 rdy=0",
                                 mem_sel, busy, in_ready, ph);
                    end
                    n_cmp++;
                    if (x !== e.tx || y !== e.ty) begin
                        n_bad++;
                        $display("FAIL tile_origin got=(%0d,%0d) required=(%0d,%0d)", x, y, e.tx, e.ty);
                    end
                    n_cmp++;
                    if ({c1, c2, c3, c4} !== {e.e1, e.e2, e.e3, e.e4}) begin
                        n_bad++;
                        $display("FAIL tile_data (%0d,%0d) ph=%0d got=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d",
                                 e.tx, e.ty, ph, c1, c2, c3, c4, e.e1, e.e2, e.e3, e.e4);
                    end
                end
                tiles++;
            end else if (mem_sel !== 2'd0) begin
                n_cmp++; n_bad++;
                $display("FAIL stray_mem_sel got=%0d required=0 or 1", mem_sel);
            end
        end
        n_cmp++;
        if (tiles != n_tiles) begin
            n_bad++;
            $display("FAIL tile_count got=%0d required=%0d", tiles, n_tiles);
        end
        if (exp_done > 0) begin
            w = 0;
            while (!done && w < 10) begin
                @(negedge clk);
                cyc++;
                w++;
            end
            n_cmp++;
            if (cyc !== exp_done || done !== 1'b1) begin
                n_bad++;
                $display("FAIL done_cycle got=%0d done=%0b required=%0d", cyc, done, exp_done);
            end
            n_cmp++;
            if (busy !== 1'b0 || mem_sel !== 2'd0 || x !== 3'd6 || y !== 3'd6) begin
                n_bad++;
                $display("FAIL done_state got busy=%0b sel=%0d x=%0d y=%0d required 0,0,6,6", busy, mem_sel, x, y);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL done_pulse got done=%0b busy=%0b required 0,0", done, busy);
            end
        end
    endtask

    task automatic run_product(input bit bubble, input int limit, input int n_tiles, input int period,
                               input int first, input int done_cyc, input bit poke);
        int cnt;
        @(negedge clk);
        start = 1'b1;
        fork
            begin
                @(negedge clk);
                start = 1'b0;
                if (poke) begin
                    repeat (3) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    cnt = 0;
                    while (mem_sel !== 2'd2 && cnt < 200) begin
                        @(negedge clk);
                        cnt++;
                    end
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            drive(bubble, limit);
            monitor(n_tiles, period, first, done_cyc);
        join
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({c1, c2, c3, c4} !== 64'd0 || x !== 3'd0 || y !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_data got c=%0d,%0d,%0d,%0d x=%0d y=%0d required zeros", c1, c2, c3, c4, x, y);
        end
        n_cmp++;
        if (mem_sel !== 2'd0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got sel=%0d rdy=%0b busy=%0b done=%0b required zeros",
                     mem_sel, in_ready, busy, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        set_mats(0);
        run_product(0, 128, 16, 11, 9, 177, 0);
    endtask

    task automatic test_overflow();
        set_mats(1);
        run_product(0, 128, 16, 11, 9, 177, 0);
    endtask

    task automatic test_distinct();
        set_mats(2);
        run_product(0, 128, 16, 11, 9, 177, 0);
    endtask

    task automatic test_backpressure();
        set_mats(2);
        run_product(1, 128, 16, 19, 17, 305, 0);
    endtask

    task automatic test_reset_mid_run();
        int stray = 0;
        set_mats(0);
        run_product(0, 44, 5, 11, 9, 0, 0);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({c1, c2, c3, c4} !== 64'd0 || x !== 3'd0 || y !== 3'd0 || mem_sel !== 2'd0 ||
            in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset got c=%0d,%0d,%0d,%0d x=%0d y=%0d sel=%0d rdy=%0b busy=%0b required zeros",
                     c1, c2, c3, c4, x, y, mem_sel, in_ready, busy);
        end
        reset = 1'b0;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (mem_sel !== 2'd0 || busy !== 1'b0 || done !== 1'b0) stray++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL post_reset_quiet got=%0d active cycles required=0", stray);
        end
        run_product(0, 128, 16, 11, 9, 177, 0);
    endtask

    task automatic test_start_ignored();
        set_mats(2);
        run_product(0, 128, 16, 11, 9, 177, 1);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_overflow();
        test_distinct();
        test_backpressure();
        test_reset_mid_run();
        test_start_ignored();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_tiles got=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_tile_engine.md
Name: systolic_tile_engine

Overview:
- Upstream compute stage that feeds systolicmemory.
- Computes an 8x8 matrix product C = A*B as sixteen 2x2 output tiles on a 2x2 array of multiply-accumulate PEs.
- Streams each finished tile into the memory using its c1..c4 / x / y / mem_sel write protocol.
- Operands arrive as a valid/ready stream: two A elements and two B elements per beat.

Parameters:
- DATA_W, 8, operand width; results are 2*DATA_W bits.
- AXIS_W, 3, matrix index width; matrix dimension N = 2**AXIS_W = 8.
- K_LEN, 8, inner-product length, in beats per tile.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a full 8x8 product; sampled only in IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- a0, a1  in  DATA_W each  A[x][k] and A[x+1][k].
- b0, b1  in  DATA_W each  B[k][y] and B[k][y+1].
- c1, c2, c3, c4  out  2*DATA_W each  results for positions [x][y], [x][y+1], [x+1][y], [x+1][y+1].
- x, y  out  AXIS_W each  tile origin; always even.
- mem_sel  out  2  write phase to memory: 0 idle, 1 writes c1, 2 writes c2 and c3, 3 writes c4.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last tile is written.

Behaviour:
- Reset: state = IDLE. c1..c4 = 0, x = y = 0, mem_sel = 0, in_ready = 0, busy = 0, done = 0. Accumulators and beat counter k are cleared.
- Reset mid-operation aborts immediately. No further writes occur; a partial tile is discarded.
- States: IDLE, ACC, WR1, WR2, WR3.
- IDLE:
  - On start: go to ACC, busy = 1, x = y = 0, accumulators = 0, k = 0.
  - start in any other state is ignored.
- ACC:
  - in_ready = 1.
  - Each accepted beat adds: acc11 += a0*b0, acc12 += a0*b1, acc21 += a1*b0, acc22 += a1*b1.
  - Products are unsigned, DATA_W x DATA_W -> 2*DATA_W. Sums wrap modulo 2**(2*DATA_W); no saturation, no overflow flag.
  - A beat is not accepted if in_valid is low. k and the accumulators then hold; bubbles are allowed anywhere.
  - Beat K_LEN-1 accepted -> go to WR1.
- c1..c4 are driven directly from acc11, acc12, acc21, acc22. They are stable throughout WR1..WR3.
- WR1: mem_sel = 1, in_ready = 0.
- WR2: mem_sel = 2.
- WR3: mem_sel = 3. Then advance the tile:
  - If y == N-2: set y = 0 and x = x+2.
  - Otherwise: y = y+2.
  - Clear accumulators and k, then return to ACC.
- Last tile (x == N-2, y == N-2) in WR3:
  - Next cycle: state = IDLE, done = 1 for exactly one cycle, busy = 0, mem_sel = 0.
  - x and y are not advanced; they hold 6,6 until the next start.
- Outside WR states, mem_sel = 0.
- x and y change only on the WR3 exit edge, so they are constant through each write sequence.
- Latency and throughput:
  - mem_sel = 1 appears on the cycle after the edge that accepts the final beat.
  - Full-rate tile period is K_LEN + 3 = 11 cycles.
  - A full product takes 176 cycles at full rate.
- in_valid while in_ready = 0 is ignored; the data is not consumed.

Decomposition:
- Shared package or include holds DATA_W and AXIS_W defaults, the mem_sel encodings (MSEL_IDLE = 0, MSEL_C1 = 1, MSEL_C23 = 2, MSEL_C4 = 3) and the state encoding.
- One sub-module, systolic_pe:
  - Inputs: clk, reset, clr, en, a, b.
  - Output: acc, a 2*DATA_W accumulator.
  - Four instances form the 2x2 array.
- Controller FSM, k counter and tile-origin counters stay in the top module.

Test Plan:
- All-ones: A = B = all 1, in_valid held high.
  - Every tile writes c1..c4 = 8.
  - Tile order is (0,0), (0,2), (0,4), (0,6), (2,0) ... (6,6), with mem_sel 1,2,3 per tile.
  - done pulses once, at cycle 177 after start.
- Overflow: A = B = all 255 -> every result is 255*255*8 mod 65536 = 61448.
- Distinct values: A[i][k] = i+1, B[k][j] = j+1 -> C[i][j] = 8*(i+1)*(j+1).
  - Example: the tile at (2,4) gives c1 = 120, c2 = 144, c3 = 160, c4 = 192.
- Backpressure: in_valid toggles 1,0,1,0 during ACC.
  - Results are identical to the full-rate run.
  - Tile period is 19 cycles.
  - No beat is lost or doubled.
- Reset mid-run: assert reset at beat 4 of tile (2,2).
  - Next cycle all outputs are 0 and the engine is in IDLE; no mem_sel pulses follow.
  - A fresh start then reproduces the all-ones result.
- start pulsed during ACC and during WR2 is ignored: no restart, and x, y, k are undisturbed.
